// File: rtl/aes_axis_tx_pkg.sv
// aes_axis_tx_pkg: shared constants and types for the AES output-side streamer.
//   BLK_S  - width of one AES block / output FIFO entry
//   WORD_S - AXI-Stream beat width
//   tx_state_e - streamer FSM state encoding
package aes_axis_tx_pkg;

    localparam int unsigned BLK_S  = 128;
    localparam int unsigned WORD_S = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StSend  = 2'd2,
        StDone  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/aes_blk_serializer.sv
// aes_blk_serializer: parallel-load shift register that emits one block as a
// sequence of words, most-significant word first.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - capture data_in and restart at word 0
//   data_in     - block to serialize
//   advance     - current word consumed; shift to the next one
//   word_out    - current (top) word
//   last_word   - current word is the final word of the block
module aes_blk_serializer
    import aes_axis_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BLK_S,
    parameter int unsigned WORD_WIDTH = WORD_S
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  advance,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  last_word
);

    localparam int unsigned WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (load) begin
            shift_q <= data_in;
            idx_q   <= '0;
        end else if (advance) begin
            shift_q <= shift_q << WORD_WIDTH;
            // Wrap explicitly so non-power-of-two word counts also restart at 0.
            idx_q   <= last_word ? '0 : idx_q + 1'b1;
        end
    end

    assign word_out  = shift_q[DATA_WIDTH-1 -: WORD_WIDTH];
    assign last_word = (idx_q == IDX_W'(WORDS - 1));

endmodule

// File: rtl/aes_axis_tx.sv
// aes_axis_tx: drains 128-bit result blocks from the AES output FIFO and
// streams each as 32-bit AXI4-Stream beats, MS word first, with tlast on the
// final beat of the job.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   start, blk_count               - job start pulse and job length in blocks
//   busy, tx_done                  - job in progress / one-cycle completion pulse
//   out_fifo_read_tvalid/tready    - output FIFO pop handshake
//   out_fifo_data                  - output FIFO head entry
//   m_axis_tvalid/tready/tdata/tstrb/tlast - AXI-Stream master
module aes_axis_tx
    import aes_axis_tx_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH      = BLK_S,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = WORD_S,
    parameter int unsigned BLK_CNT_WIDTH        = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [BLK_CNT_WIDTH-1:0]          blk_count,
    output logic                              busy,
    output logic                              tx_done,
    input  logic                              out_fifo_read_tvalid,
    output logic                              out_fifo_read_tready,
    input  logic [FIFO_DATA_WIDTH-1:0]        out_fifo_data,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                              m_axis_tlast
);

    tx_state_e                 state_q, state_d;
    logic [BLK_CNT_WIDTH-1:0]  remaining_q, remaining_d;

    logic                            ser_load;
    logic                            ser_advance;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] ser_word;
    logic                            ser_last_word;

    aes_blk_serializer #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .WORD_WIDTH (C_M_AXIS_TDATA_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .data_in   (out_fifo_data),
        .advance   (ser_advance),
        .word_out  (ser_word),
        .last_word (ser_last_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // All outputs decode from the registered state, so tvalid never depends on
    // tready and everything reads 0 the cycle after reset.
    always_comb begin
        state_d              = state_q;
        remaining_d          = remaining_q;
        ser_load             = 1'b0;
        ser_advance          = 1'b0;
        busy                 = 1'b0;
        tx_done              = 1'b0;
        out_fifo_read_tready = 1'b0;
        m_axis_tvalid        = 1'b0;
        m_axis_tdata         = '0;
        m_axis_tstrb         = '0;
        m_axis_tlast         = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (blk_count != '0) begin
                        remaining_d = blk_count;
                        state_d     = StFetch;
                    end else begin
                        // Empty job: complete immediately without touching the FIFO.
                        state_d = StDone;
                    end
                end
            end

            StFetch: begin
                busy                 = 1'b1;
                out_fifo_read_tready = 1'b1;
                if (out_fifo_read_tvalid) begin
                    ser_load = 1'b1;
                    state_d  = StSend;
                end
            end

            StSend: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = ser_word;
                m_axis_tstrb  = '1;
                m_axis_tlast  = (remaining_q == BLK_CNT_WIDTH'(1)) && ser_last_word;
                if (m_axis_tready) begin
                    ser_advance = 1'b1;
                    if (ser_last_word) begin
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - 1'b1;
                        end
                        state_d = (remaining_q <= BLK_CNT_WIDTH'(1)) ? StDone : StFetch;
                    end
                end
            end

            StDone: begin
                tx_done = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/aes_axis_tx.md
Name: aes_axis_tx

Overview:
Output-side streamer for the AES engine. It drains 128-bit result blocks from the output FIFO, which the AES controller fills, and serializes each block into 32-bit AXI4-Stream master beats toward the DMA. It asserts tlast on the final beat of the final block of a job. The job length in blocks is supplied by the slave-side logic at job start.

Parameters:
FIFO_DATA_WIDTH, 128, width of one output FIFO entry (one AES block).
C_M_AXIS_TDATA_WIDTH, 32, AXI-Stream beat width; FIFO_DATA_WIDTH must be an exact multiple of it.
BLK_CNT_WIDTH, 16, width of the block counter (maximum job length is 2^BLK_CNT_WIDTH-1 blocks).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle job start; samples blk_count
blk_count  in  BLK_CNT_WIDTH  number of output blocks in the job
busy  out  1  high from accepted start until tx_done
tx_done  out  1  single-cycle pulse after the last beat is accepted
out_fifo_read_tvalid  in  1  output FIFO has data
out_fifo_read_tready  out  1  pop request to output FIFO
out_fifo_data  in  FIFO_DATA_WIDTH  output FIFO head entry
m_axis_tvalid  out  1  AXI-Stream valid
m_axis_tready  in  1  AXI-Stream ready
m_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  beat data
m_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes
m_axis_tlast  out  1  last beat of job

Behaviour:
- Reset: synchronous, active-high, on clk. It forces all outputs to 0, state to IDLE, and clears counters and the shift register. Reset mid-job abandons the job: no tx_done, no further beats. FIFO contents are not touched.
- WORDS = FIFO_DATA_WIDTH/C_M_AXIS_TDATA_WIDTH (4 by default).
- Word order: most-significant word first. Beat 0 carries bits [127:96]; beat 3 carries bits [31:0].
- State machine: IDLE, FETCH, SEND, DONE.
- IDLE
  - start with blk_count != 0: latch remaining = blk_count, set busy = 1, go to FETCH.
  - start with blk_count == 0: go to DONE, so that tx_done pulses on the next cycle; no beats are sent.
- FETCH
  - out_fifo_read_tready = 1, combinationally from state.
  - On out_fifo_read_tvalid && out_fifo_read_tready: load the shift register with out_fifo_data, set word_idx = 0, go to SEND.
  - An empty FIFO holds FETCH indefinitely.
- SEND
  - m_axis_tvalid = 1.
  - m_axis_tdata = shift register top word.
  - m_axis_tstrb = all ones.
  - m_axis_tlast = (remaining == 1) && (word_idx == WORDS-1).
  - On m_axis_tready: shift left by C_M_AXIS_TDATA_WIDTH, word_idx++.
  - On acceptance of word WORDS-1: remaining--. If remaining was 1, go to DONE; otherwise go to FETCH.
- DONE: tx_done = 1 for exactly one cycle, busy = 0, return to IDLE.
- AXI rules:
  - While m_axis_tvalid = 1 and m_axis_tready = 0, tdata, tstrb and tlast hold stable.
  - tvalid never drops without a handshake, except on reset.
  - tvalid does not depend on tready.
- Latency and throughput:
  - First beat is valid 1 cycle after the FIFO pop, i.e. 2 cycles after start when the FIFO is non-empty.
  - Throughput is WORDS beats per WORDS+1 cycles (one FETCH bubble per block). Prefetch is not required.
- start while busy is ignored: counters are unaffected and the job continues.
- Datapath arithmetic:
  - remaining is unsigned BLK_CNT_WIDTH and never decrements below 0.
  - word_idx is $clog2(WORDS) bits and wraps to 0 after each block.

Decomposition:
- Shared header (aes.vh): BLK_S (128) and WORD_S (32) are reused for the defaults. State encodings remain local parameters.
- One natural sub-module, aes_blk_serializer, holds the parallel-load shift register and word counter. Its ports are load, data_in, advance, word_out, last_word.
- The top level keeps the FSM, remaining counter and handshake logic.

Test Plan:
1. blk_count=1; FIFO holds 0x00112233_44556677_8899AABB_CCDDEEFF; tready=1 -> beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF. tlast only on the 4th beat, tstrb=0xF, tx_done one cycle after the 4th beat, busy low afterwards.
2. blk_count=3 with FIFO entries arriving 10 cycles apart -> out_fifo_read_tready high while waiting, 12 beats in order, exactly one tlast (beat 12), exactly one tx_done pulse.
3. Random tready backpressure (~50%) over 2 blocks -> tdata/tlast stable during every stall, no beat lost or duplicated, 8 beats total.
4. start with blk_count=0 -> no tvalid, no FIFO pop, tx_done pulse 1 cycle later.
5. Second start pulse during block 1 of a 2-block job -> ignored; exactly 8 beats and one tx_done.
6. reset asserted after beat 2 of block 1 -> next cycle all outputs 0, state IDLE. A new start with blk_count=1 then streams the next FIFO entry correctly.
